// File: rtl/mem_arbiter_pkg.sv
// Shared codes for the fetch/data Avalon-MM arbiter: FSM states, grant owner, bus-error fill word.
package mem_arbiter_pkg;

   localparam int SIZE_W = 32;
   typedef logic [SIZE_W-1:0] size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUS_IF,
      BUS_D,
      BUS_ERR
   } arb_state_t;

   typedef enum logic {
      GRANT_FETCH,
      GRANT_DATA
   } grant_t;

   localparam size_t BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector, purely combinational; req[0]=fetch, req[1]=data.
module mem_arbiter_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output grant_t     grant
);

   always_comb begin
      grant = GRANT_FETCH;
      if (req == 2'b11) begin
         grant = (last_grant == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
      end else if (req[1]) begin
         grant = GRANT_DATA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Avalon-MM master between fetch and data requesters; ack two cycles after request plus wait states.
// MEM_ARBITER_TIMEOUT_EN adds a waitrequest watchdog that forces an error ack and sets sticky err_o.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W         = SIZE_W,
   parameter int DATA_W         = SIZE_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_ack_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   output logic                d_ack_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                busy_o,
   output logic                err_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                waitrequest_i,
   output logic [DATA_W-1:0]   writedata_o,
   output logic [DATA_W/8-1:0] byteenable_o,
   input  logic [DATA_W-1:0]   readdata_i
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   grant_t            pick;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [1:0]        pick_req;

   // A req still high during its own ack cycle belongs to the finished access.
   assign pick_req = {d_req_i & ~d_ack_q, if_req_i & ~if_ack_q};

   mem_arbiter_rr_pick u_rr_pick (
      .req        (pick_req),
      .last_grant (last_grant_q),
      .grant      (pick)
   );

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      read_d       = read_q;
      write_d      = write_q;
      if_ack_d     = 1'b0;
      d_ack_d      = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pick_req) begin
`ifdef MEM_ARBITER_TIMEOUT_EN
               cnt_d = '0;
`endif
               if (pick == GRANT_FETCH) begin
                  state_d = BUS_IF;
                  addr_d  = if_addr_i;
                  be_d    = '1;
                  read_d  = 1'b1;
                  write_d = 1'b0;
               end else begin
                  state_d = BUS_D;
                  addr_d  = d_addr_i;
                  wdata_d = d_wdata_i;
                  be_d    = d_be_i;
                  read_d  = ~d_we_i;
                  write_d = d_we_i;
               end
            end
         end
         BUS_IF, BUS_D: begin
            if (!waitrequest_i) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = IDLE;
               if (state_q == BUS_IF) begin
                  if_ack_d     = 1'b1;
                  if_rdata_d   = readdata_i;
                  last_grant_d = GRANT_FETCH;
               end else begin
                  d_ack_d      = 1'b1;
                  last_grant_d = GRANT_DATA;
                  if (read_q) begin
                     d_rdata_d = readdata_i;
                  end
               end
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               err_d   = 1'b1;
               state_d = BUS_ERR;
               if (state_q == BUS_IF) begin
                  if_ack_d     = 1'b1;
                  if_rdata_d   = DATA_W'(BUS_ERR_DATA);
                  last_grant_d = GRANT_FETCH;
               end else begin
                  d_ack_d      = 1'b1;
                  d_rdata_d    = DATA_W'(BUS_ERR_DATA);
                  last_grant_d = GRANT_DATA;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         BUS_ERR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_FETCH;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         read_q       <= read_d;
         write_q      <= write_d;
         if_ack_q     <= if_ack_d;
         d_ack_q      <= d_ack_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign busy_o       = (state_q != IDLE) | if_req_i | d_req_i;
   assign address_o    = addr_q;
   assign writedata_o  = wdata_q;
   assign byteenable_o = be_q;
   assign read_o       = read_q;
   assign write_o      = write_q;
   assign if_ack_o     = if_ack_q;
   assign d_ack_o      = d_ack_q;
   assign if_rdata_o   = if_rdata_q;
   assign d_rdata_o    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-requester run against a word-level model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        if_req_i, d_req_i, d_we_i, waitrequest_i;
   logic [31:0] if_addr_i, d_addr_i, d_wdata_i, readdata_i;
   logic [3:0]  d_be_i;
   logic        if_ack_o, d_ack_o, busy_o, err_o, read_o, write_o;
   logic [31:0] if_rdata_o, d_rdata_o, address_o, writedata_o;
   logic [3:0]  byteenable_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] slave_mem [16];
   logic [31:0] ref_mem   [16];
   logic        slave_init = 1'b0;
   logic        force_en   = 1'b0;
   logic [31:0] force_val  = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_i(reset_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_be_i(d_be_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
      .busy_o(busy_o), .err_o(err_o),
      .address_o(address_o), .read_o(read_o), .write_o(write_o), .waitrequest_i(waitrequest_i),
      .writedata_o(writedata_o), .byteenable_o(byteenable_o), .readdata_i(readdata_i)
   );

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] init_val(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   function automatic bit in_dreg(input logic [31:0] a);
      return a[31:6] == 26'h40;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Avalon slave: a small writable window at 0x1000, a hashed ROM elsewhere.
   always_comb begin
      readdata_i = rd_fn(address_o);
      if (force_en) readdata_i = force_val;
      else if (in_dreg(address_o)) readdata_i = slave_mem[address_o[5:2]];
   end

   always @(posedge clk) begin
      if (!slave_init) begin
         for (int i = 0; i < 16; i++) slave_mem[i] <= init_val(i);
         slave_init <= 1'b1;
      end else if (reset_i && write_o && !waitrequest_i && in_dreg(address_o)) begin
         slave_mem[address_o[5:2]] <= merge(slave_mem[address_o[5:2]], writedata_o, byteenable_o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0; waitrequest_i = 1'b0;
      step(); step();
      reset_i = 1'b1;
      step();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      total++;
      if ({if_ack_o, d_ack_o, read_o, write_o, busy_o, err_o} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=000000", {if_ack_o, d_ack_o, read_o, write_o, busy_o, err_o});
      end
      total++;
      if ({address_o, writedata_o, byteenable_o, if_rdata_o, d_rdata_o} !== 132'b0) begin
         bad++; $display("FAIL reset_data got=%h exp=0", {address_o, writedata_o, byteenable_o, if_rdata_o, d_rdata_o});
      end
      reset_i = 1'b1;
      step();
   endtask

   task automatic test_fetch();
      force_en = 1'b1; force_val = 32'h2402_0005;
      step();
      if_addr_i = 32'hBFC0_0000; if_req_i = 1'b1; waitrequest_i = 1'b0;
      #1;
      total++;
      if ({read_o, write_o} !== 2'b00) begin bad++; $display("FAIL fetch_n_strobe got=%b exp=00", {read_o, write_o}); end
      step(); #1;
      total++;
      if ({read_o, write_o, if_ack_o, address_o, byteenable_o} !== {3'b100, 32'hBFC0_0000, 4'hF}) begin
         bad++; $display("FAIL fetch_n1_bus got=%h exp=%h", {read_o, write_o, if_ack_o, address_o, byteenable_o},
                         {3'b100, 32'hBFC0_0000, 4'hF});
      end
      step(); #1;
      total++;
      if ({if_ack_o, read_o, write_o, if_rdata_o} !== {3'b100, 32'h2402_0005}) begin
         bad++; $display("FAIL fetch_n2_ack got=%h exp=%h", {if_ack_o, read_o, write_o, if_rdata_o}, {3'b100, 32'h2402_0005});
      end
      if_req_i = 1'b0;
      step(); #1;
      total++;
      if ({if_ack_o, if_rdata_o} !== {1'b0, 32'h2402_0005}) begin
         bad++; $display("FAIL fetch_hold got=%h exp=%h", {if_ack_o, if_rdata_o}, {1'b0, 32'h2402_0005});
      end
      force_en = 1'b0;
   endtask

   task automatic test_both();
      logic [31:0] seen [4];
      logic [31:0] exp_seq [4];
      int n = 0;
      bit wr_seen = 0;
      exp_seq[0] = 32'h2000_0040; exp_seq[1] = 32'h0000_0100;
      exp_seq[2] = 32'h2000_0040; exp_seq[3] = 32'h0000_0100;
      apply_reset();
      if_addr_i = 32'h0000_0100; d_addr_i = 32'h2000_0040; d_we_i = 1'b0;
      if_req_i = 1'b1; d_req_i = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         step(); #1;
         if (write_o) wr_seen = 1;
         if (read_o) begin seen[n] = address_o; n++; end
      end
      if_req_i = 1'b0; d_req_i = 1'b0;
      total++;
      if (n != 4 || wr_seen) begin bad++; $display("FAIL both_grants got=%0d wr=%0d exp=4 wr=0", n, wr_seen); end
      for (int k = 0; k < n; k++) begin
         total++;
         if (seen[k] !== exp_seq[k]) begin bad++; $display("FAIL both_order[%0d] got=%h exp=%h", k, seen[k], exp_seq[k]); end
      end
      for (int c = 0; c < 10 && busy_o; c++) step();
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL both_drain got=%b exp=0", busy_o); end
   endtask

   task automatic test_write_wait();
      logic [71:0] exp_bus;
      exp_bus = {4'b1001, 32'h0000_1000, 32'h1234_5678, 4'b0011};
      step();
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_1000; d_wdata_i = 32'h1234_5678;
      d_be_i = 4'b0011; waitrequest_i = 1'b1;
      #1;
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy_req got=%b exp=1", busy_o); end
      for (int k = 0; k < 4; k++) begin
         step();
         waitrequest_i = (k < 3);
         #1;
         total++;
         if ({write_o, read_o, d_ack_o, busy_o, address_o, writedata_o, byteenable_o} !== exp_bus) begin
            bad++; $display("FAIL wr_hold[%0d] got=%h exp=%h", k,
                            {write_o, read_o, d_ack_o, busy_o, address_o, writedata_o, byteenable_o}, exp_bus);
         end
      end
      step();
      waitrequest_i = 1'b0;
      #1;
      total++;
      if ({d_ack_o, write_o, read_o, busy_o} !== 4'b1001) begin
         bad++; $display("FAIL wr_ack got=%b exp=1001", {d_ack_o, write_o, read_o, busy_o});
      end
      d_req_i = 1'b0;
      ref_mem[0] = merge(ref_mem[0], 32'h1234_5678, 4'b0011);
      #1;
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL wr_idle got=%b exp=0", busy_o); end
      step(); #1;
      total++;
      if (d_ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0", d_ack_o); end
   endtask

   task automatic test_random();
      bit f_pend = 0, d_pend = 0, d_rd = 0, issuing = 1, prev_hold = 0;
      logic [31:0] f_exp = '0, d_exp = '0, a;
      logic [69:0] prev_bus = '0, cur_bus;
      int f_age = 0, d_age = 0, idx, cyc = 0;
      while (cyc < 2400) begin
         step();
         cyc++;
         if (cyc == 2000) issuing = 0;
         cur_bus = {read_o, write_o, address_o, writedata_o, byteenable_o};
         total++;
         if (read_o && write_o) begin bad++; $display("FAIL rnd_rw_excl cyc=%0d got=11 exp=not both", cyc); end
         if (prev_hold) begin
            total++;
            if (cur_bus !== prev_bus) begin bad++; $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", cyc, cur_bus, prev_bus); end
         end
         if (if_ack_o) begin
            total++;
            if (!f_pend || if_rdata_o !== f_exp) begin
               bad++; $display("FAIL rnd_fetch cyc=%0d pend=%0d got=%h exp=%h", cyc, f_pend, if_rdata_o, f_exp);
            end
            f_pend = 0;
         end
         if (d_ack_o) begin
            total++;
            if (!d_pend || (d_rd && d_rdata_o !== d_exp)) begin
               bad++; $display("FAIL rnd_data cyc=%0d pend=%0d rd=%0d got=%h exp=%h", cyc, d_pend, d_rd, d_rdata_o, d_exp);
            end
            d_pend = 0;
         end
         f_age = f_pend ? f_age + 1 : 0;
         d_age = d_pend ? d_age + 1 : 0;
         if (f_age > 200 || d_age > 200) begin
            total++; bad++;
            $display("FAIL rnd_stall cyc=%0d f_age=%0d d_age=%0d exp=<=200", cyc, f_age, d_age);
            break;
         end
         if (!issuing && !f_pend && !d_pend) break;
         if (!f_pend) begin
            if (issuing && $urandom_range(0, 1) == 1) begin
               a = $urandom; a[31] = 1'b1; a[1:0] = 2'b00;
               if_addr_i = a; f_exp = rd_fn(a); if_req_i = 1'b1; f_pend = 1;
            end else if_req_i = 1'b0;
         end
         if (!d_pend) begin
            if (issuing && $urandom_range(0, 1) == 1) begin
               idx = $urandom_range(0, 15);
               d_addr_i = 32'h0000_1000 + 32'(idx * 4);
               d_we_i = 1'($urandom_range(0, 1));
               d_wdata_i = $urandom; d_be_i = 4'($urandom);
               if (d_we_i) ref_mem[idx] = merge(ref_mem[idx], d_wdata_i, d_be_i);
               else d_exp = ref_mem[idx];
               d_rd = !d_we_i; d_req_i = 1'b1; d_pend = 1;
            end else d_req_i = 1'b0;
         end
         waitrequest_i = ($urandom_range(0, 2) == 0);
         prev_hold = (read_o | write_o) && waitrequest_i;
         prev_bus = cur_bus;
      end
      total++;
      if (f_pend || d_pend) begin bad++; $display("FAIL rnd_drain got f=%0d d=%0d exp=0 0", f_pend, d_pend); end
      waitrequest_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0;
      step(); step();
   endtask

   task automatic test_async_reset();
      bit saw_ack = 0;
      step();
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0300; waitrequest_i = 1'b1;
      step();
      step();
      total++;
      if (read_o !== 1'b1) begin bad++; $display("FAIL arst_pre_strobe got=%b exp=1", read_o); end
      #2;
      reset_i = 1'b0;
      #1;
      total++;
      if ({read_o, write_o, address_o} !== 34'b0) begin
         bad++; $display("FAIL arst_drop got=%h exp=0", {read_o, write_o, address_o});
      end
      d_req_i = 1'b0;
      repeat (3) begin step(); if (if_ack_o || d_ack_o) saw_ack = 1; end
      reset_i = 1'b1;
      repeat (4) begin step(); if (if_ack_o || d_ack_o) saw_ack = 1; end
      total++;
      if (saw_ack || d_rdata_o !== 32'h0) begin
         bad++; $display("FAIL arst_no_ack got ack=%0d rdata=%h exp ack=0 rdata=0", saw_ack, d_rdata_o);
      end
      waitrequest_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
      #1;
      total++;
      if ({busy_o, read_o} !== 2'b10) begin bad++; $display("FAIL arst_idle got=%b exp=10", {busy_o, read_o}); end
      step(); #1;
      total++;
      if ({read_o, address_o} !== {1'b1, 32'h0000_0500}) begin
         bad++; $display("FAIL arst_regrant got=%h exp=%h", {read_o, address_o}, {1'b1, 32'h0000_0500});
      end
      step(); #1;
      total++;
      if ({if_ack_o, if_rdata_o} !== {1'b1, rd_fn(32'h0000_0500)}) begin
         bad++; $display("FAIL arst_ack got=%h exp=%h", {if_ack_o, if_rdata_o}, {1'b1, rd_fn(32'h0000_0500)});
      end
      if_req_i = 1'b0;
      step();
   endtask

   task automatic test_stuck();
      bit saw_ack = 0, busy_low = 0, strobe_low = 0;
      step();
      waitrequest_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
`ifdef MEM_ARBITER_TIMEOUT_EN
      for (int k = 1; k <= 4; k++) begin
         step(); #1;
         total++;
         if ({read_o, if_ack_o, err_o} !== 3'b100) begin
            bad++; $display("FAIL to_wait[%0d] got=%b exp=100", k, {read_o, if_ack_o, err_o});
         end
      end
      step(); #1;
      total++;
      if ({if_ack_o, err_o, read_o, if_rdata_o} !== {3'b110, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL to_ack got=%h exp=%h", {if_ack_o, err_o, read_o, if_rdata_o}, {3'b110, 32'hDEAD_BEEF});
      end
      if_req_i = 1'b0; waitrequest_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         total++;
         if ({err_o, if_ack_o} !== 2'b10) begin bad++; $display("FAIL to_sticky[%0d] got=%b exp=10", k, {err_o, if_ack_o}); end
      end
`else
      repeat (100) begin
         step(); #1;
         if (if_ack_o) saw_ack = 1;
         if (!busy_o) busy_low = 1;
         if (!read_o) strobe_low = 1;
      end
      total++;
      if (saw_ack || busy_low) begin
         bad++; $display("FAIL stuck_wait got ack=%0d busy_low=%0d exp=0 0", saw_ack, busy_low);
      end
      total++;
      if (strobe_low || err_o !== 1'b0) begin
         bad++; $display("FAIL stuck_bus got strobe_low=%0d err=%b exp=0 0", strobe_low, err_o);
      end
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
      waitrequest_i = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      test_reset();
      test_fetch();
      test_both();
      test_write_wait();
      test_random();
      test_async_reset();
      test_stuck();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single Avalon-MM master port between two requesters: the instruction-fetch path (PC) and the data path (load/store).
- Registers each accepted request and holds it on the bus until waitrequest clears.
- Captures read data and returns a one-cycle acknowledge per requester.
- Drives busy_o into the FSM stall input, replacing the pending waitrequest-stall TODO in the top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, bus-watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle pulse: fetch complete.
- if_rdata_o  out  DATA_W  fetched word; valid on if_ack_o, held until the next fetch ack.
- d_req_i  in  1  data request; held until d_ack_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_be_i  in  DATA_W/8  byte enables.
- d_ack_o  out  1  one-cycle pulse: data access complete.
- d_rdata_o  out  DATA_W  load word; valid on d_ack_o, held until the next data ack.
- busy_o  out  1  a transaction is in flight or a request is not yet acked.
- err_o  out  1  sticky bus-timeout flag.
- address_o  out  ADDR_W  Avalon address.
- read_o  out  1  Avalon read.
- write_o  out  1  Avalon write.
- waitrequest_i  in  1  Avalon waitrequest.
- writedata_o  out  DATA_W  Avalon write data.
- byteenable_o  out  DATA_W/8  Avalon byte enables.
- readdata_i  in  DATA_W  Avalon read data; valid in the cycle where read_o=1 and waitrequest_i=0.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=IDLE; all acks, read_o, write_o and busy_o=0.
  - address_o, writedata_o, byteenable_o, if_rdata_o, d_rdata_o all 0.
  - last_grant=FETCH; err_o=0.
  - Reset mid-transaction drops read_o/write_o immediately; the abandoned access is never acked.
- States: IDLE, BUS_IF, BUS_D (plus BUS_ERR with the optional feature).
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it, latch address (plus we/wdata/be for data) into output registers.
  - Both requests: grant the requester not granted last (round-robin on last_grant).
  - Move to BUS_IF or BUS_D; read_o/write_o are asserted from the next cycle.
- BUS_x:
  - Hold address_o, writedata_o, byteenable_o, read_o and write_o constant while waitrequest_i=1.
  - Fetch always uses read_o=1 and byteenable_o=all ones.
  - First cycle with waitrequest_i=0:
    - For a read, register readdata_i into the owner's rdata register.
    - Pulse the owner's ack next cycle, deassert read_o/write_o, update last_grant, return to IDLE.
- Latency with zero wait states:
  - Request seen in cycle N; bus strobe in N+1; ack and rdata valid in N+2.
  - Each wait cycle adds 1.
  - IDLE is entered on the ack cycle; a new grant is possible in that cycle.
- Back-to-back operation:
  - A requester may deassert req on its ack cycle or keep it high for a new access.
  - A req still high in the ack cycle counts as a new request only from the following cycle, so one held req cannot be double-granted.
- Request withdrawn before ack: the access still completes and the ack still pulses; the requester ignores it.
- busy_o = (state != IDLE) | if_req_i | d_req_i, combinational, with acks excluded; the FSM stalls while busy_o=1.
- Never asserts read_o and write_o together.
- Other address bits pass through unmodified; no alignment checks.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Enabled:
  - An 8..32-bit counter clears on each grant and increments in BUS_x while waitrequest_i=1.
  - On reaching TIMEOUT_CYCLES: deassert strobes, set err_o (sticky until reset), pulse the owner's ack with rdata=32'hDEAD_BEEF, enter BUS_ERR for one cycle, then IDLE.
- Disabled: no counter; err_o tied 0; waits indefinitely.

Decomposition:
- Shared codes package:
  - arb_state_t enum (IDLE, BUS_IF, BUS_D, BUS_ERR).
  - grant_t enum (GRANT_FETCH, GRANT_DATA).
  - Constant BUS_ERR_DATA = 32'hDEAD_BEEF.
  - Reuse of size_t for address/data.
- One sub-module, rr_pick:
  - Combinational two-way round-robin selector; inputs req[1:0] and last_grant, output grant.
  - The FSM and registers stay in mem_arbiter.

Test Plan:
- Fetch only, waitrequest=0, if_addr=32'hBFC0_0000, readdata=32'h2402_0005:
  - read_o at N+1 with address 32'hBFC0_0000; if_ack_o at N+2; if_rdata_o=32'h2402_0005; write_o never high.
- Both requests in the same cycle after reset:
  - Data granted first (last_grant reset=FETCH), fetch granted next.
  - Repeat with both held: grants alternate D,F,D,F.
- Data write, d_addr=32'h0000_1000, d_wdata=32'h1234_5678, d_be=4'b0011, waitrequest high 3 cycles:
  - All bus outputs constant for 4 cycles; write_o=1 throughout; d_ack_o exactly one cycle later; busy_o high throughout.
- Async reset asserted in the 2nd wait cycle of a read:
  - read_o falls without a clock edge; no ack is ever produced.
  - After release, the next request starts from IDLE.
- MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high:
  - Ack after 4 wait cycles with rdata=32'hDEAD_BEEF; err_o=1 and sticky.
  - Without the macro, the same stimulus keeps busy_o high with no ack for 100 cycles.
